// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the memory-access path: memory instruction codes,
// access-size encoding and the sequencer state type.
package mips_cpu_pkg;

    // Decoded instruction codes that touch memory; every other value is a
    // non-memory instruction (code 46 is deliberately absent).
    typedef enum logic [6:0] {
        OP_LB  = 7'd42,
        OP_LBU = 7'd43,
        OP_LH  = 7'd44,
        OP_LHU = 7'd45,
        OP_LW  = 7'd47,
        OP_LWL = 7'd48,
        OP_LWR = 7'd49,
        OP_SB  = 7'd50,
        OP_SH  = 7'd51,
        OP_SW  = 7'd52
    } mem_code_e;

    // Width of a memory access as presented on access_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } seq_state_e;

    localparam int         WAIT_W   = 8;
    localparam logic [7:0] WAIT_MAX = 8'hFF;

endpackage

// File: rtl/mem_instr_classifier.sv
// Combinational decode of an instruction code into memory/load/size flags.
module mem_instr_classifier
    import mips_cpu_pkg::*;
#(
    parameter int CODE_W = 7
) (
    input  logic [CODE_W-1:0] code_i,
    output logic              is_mem_o,
    output logic              is_load_o,
    output access_size_e      size_o
);

    // Map each memory opcode to its direction and width; anything else is non-memory.
    always_comb begin
        is_mem_o  = 1'b0;
        is_load_o = 1'b0;
        size_o    = SIZE_BYTE;
        case (code_i)
            CODE_W'(OP_LB), CODE_W'(OP_LBU): begin
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
                size_o    = SIZE_BYTE;
            end
            CODE_W'(OP_LH), CODE_W'(OP_LHU): begin
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
                size_o    = SIZE_HALF;
            end
            CODE_W'(OP_LW), CODE_W'(OP_LWL), CODE_W'(OP_LWR): begin
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
                size_o    = SIZE_WORD;
            end
            CODE_W'(OP_SB): begin
                is_mem_o = 1'b1;
                size_o   = SIZE_BYTE;
            end
            CODE_W'(OP_SH): begin
                is_mem_o = 1'b1;
                size_o   = SIZE_HALF;
            end
            CODE_W'(OP_SW): begin
                is_mem_o = 1'b1;
                size_o   = SIZE_WORD;
            end
            default: begin
                is_mem_o  = 1'b0;
                is_load_o = 1'b0;
                size_o    = SIZE_BYTE;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one memory read/write per issued memory instruction, holding the
// pipeline while the bus is busy and latching a sticky error if the bus never
// accepts the access within TIMEOUT request cycles.
module mem_access_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int CODE_W  = 7,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] instruction_code,
    input  logic              issue,
    input  logic              waitrequest,
    output logic              read,
    output logic              write,
    output logic [1:0]        access_size,
    output logic              stall,
    output logic              done,
    output logic              timeout,
    output logic [7:0]        wait_count
);

    localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic              is_load_q, is_load_d;
    access_size_e      size_q, size_d;
    logic [WAIT_W-1:0] wait_count_q, wait_count_d;

    logic         cls_is_mem;
    logic         cls_is_load;
    access_size_e cls_size;

    mem_instr_classifier #(
        .CODE_W(CODE_W)
    ) u_classifier (
        .code_i    (instruction_code),
        .is_mem_o  (cls_is_mem),
        .is_load_o (cls_is_load),
        .size_o    (cls_size)
    );

    // State and captured-access registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            is_load_q    <= 1'b0;
            size_q       <= SIZE_BYTE;
            wait_count_q <= '0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            size_q       <= size_d;
            wait_count_q <= wait_count_d;
        end
    end

    // Next-state, capture and output decode.
    always_comb begin
        state_d      = state_q;
        is_load_d    = is_load_q;
        size_d       = size_q;
        wait_count_d = wait_count_q;
        read         = 1'b0;
        write        = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        stall        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (issue && cls_is_mem) begin
                    // Stall in the issue cycle itself so the pipeline holds immediately.
                    stall        = 1'b1;
                    state_d      = ST_REQ;
                    is_load_d    = cls_is_load;
                    size_d       = cls_size;
                    wait_count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                read  = is_load_q;
                write = ~is_load_q;
                if (!waitrequest) begin
                    state_d = ST_DONE;
                end else begin
                    if (wait_count_q != WAIT_MAX) begin
                        wait_count_d = wait_count_q + 8'd1;
                    end
                    // The TIMEOUT-th refused request cycle gives up on the bus.
                    if (wait_count_q == TIMEOUT_M1) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                stall   = 1'b1;
                timeout = 1'b1;
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign access_size = size_q;
    assign wait_count  = wait_count_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: the driver queues the expected
// result of every memory access; a monitor checks each done pulse against it.
module tb_mem_access_sequencer;

    localparam int CODE_W  = 7;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [CODE_W-1:0] instruction_code;
    logic              issue;
    logic              waitrequest;
    logic              read;
    logic              write;
    logic [1:0]        access_size;
    logic              stall;
    logic              done;
    logic              timeout;
    logic [7:0]        wait_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit         is_load;
        logic [1:0] size;
        int         nwait;
    } exp_t;

    exp_t sb[$];

    // Reference table of memory instructions: code, width, direction.
    int ref_codes[10] = '{42, 43, 44, 45, 47, 48, 49, 50, 51, 52};
    int ref_sizes[10] = '{0, 0, 1, 1, 2, 2, 2, 0, 1, 2};
    bit ref_loads[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};

    mem_access_sequencer #(
        .CODE_W  (CODE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .instruction_code (instruction_code),
        .issue            (issue),
        .waitrequest      (waitrequest),
        .read             (read),
        .write            (write),
        .access_size      (access_size),
        .stall            (stall),
        .done             (done),
        .timeout          (timeout),
        .wait_count       (wait_count)
    );

    always #10 clk = ~clk;

    function automatic int ref_index(input int code);
        for (int i = 0; i < 10; i++) begin
            if (ref_codes[i] == code) return i;
        end
        return -1;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Issue one instruction (caller is just after a falling edge). For a memory
    // code, queue the expected result and run the bus for nwait refused cycles
    // followed by one accepted cycle, driving junk issues that must be ignored.
    task automatic do_access(input int code, input int nwait);
        int   idx;
        exp_t e;
        idx              = ref_index(code);
        issue            = 1'b1;
        instruction_code = CODE_W'(code);
        #1;
        check($sformatf("stall_on_issue code=%0d", code), 32'(stall), 32'(idx >= 0));
        @(posedge clk);
        if (idx >= 0) begin
            e.is_load = ref_loads[idx];
            e.size    = 2'(ref_sizes[idx]);
            e.nwait   = nwait;
            sb.push_back(e);
            for (int k = 0; k <= nwait; k++) begin
                @(negedge clk);
                waitrequest      = (k < nwait);
                issue            = 1'($urandom);
                instruction_code = CODE_W'($urandom);
                @(posedge clk);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        issue = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rst_read", 32'(read), 0);
        check("rst_write", 32'(write), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_wait_count", 32'(wait_count), 0);
        check("rst_access_size", 32'(access_size), 0);
        check("rst_stall", 32'(stall), 0);
        #1 reset = 1'b0;
    endtask

    // Monitor: counts strobe cycles, checks every done pulse against the scoreboard.
    int   mon_strobes   = 0;
    bit   mon_last_load = 0;
    bit   mon_prev_done = 0;
    exp_t got;

    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            check("read_write_exclusive", 32'(read && write), 0);
            if (read || write) begin
                mon_strobes++;
                mon_last_load = read;
                check("stall_during_strobe", 32'(stall), 1);
            end
            if (done) begin
                check("done_single_pulse", 32'(mon_prev_done), 0);
                if (sb.size() == 0) begin
                    check("done_expected", 0, 1);
                end else begin
                    got = sb.pop_front();
                    check("access_size", 32'(access_size), 32'(got.size));
                    check("wait_count", 32'(wait_count), 32'(got.nwait));
                    check("strobe_cycles", 32'(mon_strobes), 32'(got.nwait + 1));
                    check("strobe_kind_is_read", 32'(mon_last_load), 32'(got.is_load));
                    check("no_timeout", 32'(timeout), 0);
                end
                mon_strobes = 0;
            end
            mon_prev_done = done;
        end
    end

    always @(posedge reset) mon_strobes = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int code;
        int r;
        reset            = 1'b1;
        issue            = 1'b0;
        waitrequest      = 1'b0;
        instruction_code = '0;

        // Reset state while held.
        repeat (2) @(negedge clk);
        #1;
        check("init_read", 32'(read), 0);
        check("init_write", 32'(write), 0);
        check("init_done", 32'(done), 0);
        check("init_timeout", 32'(timeout), 0);
        check("init_stall", 32'(stall), 0);
        check("init_wait_count", 32'(wait_count), 0);
        check("init_access_size", 32'(access_size), 0);
        #1 reset = 1'b0;

        // Single-cycle LW, then SB with three refused cycles.
        @(negedge clk); do_access(47, 0);
        @(negedge clk); issue = 1'b0; @(posedge clk);
        @(negedge clk); do_access(50, 3);
        @(negedge clk); issue = 1'b0; @(posedge clk);

        // Back-to-back LW then SW with no idle cycle in between.
        @(negedge clk); do_access(47, 0);
        @(negedge clk); do_access(52, 0);

        // Non-memory codes leave the sequencer idle.
        @(negedge clk); do_access(46, 0);
        @(negedge clk); issue = 1'b0; #1;
        check("nonmem46_read", 32'(read), 0);
        check("nonmem46_write", 32'(write), 0);
        @(posedge clk);
        @(negedge clk); do_access(10, 0);
        @(negedge clk); issue = 1'b0; #1;
        check("nonmem10_read", 32'(read), 0);
        check("nonmem10_write", 32'(write), 0);
        check("nonmem10_done", 32'(done), 0);
        @(posedge clk);

        // Timeout: LH with the bus refusing forever.
        @(negedge clk);
        issue = 1'b1; instruction_code = CODE_W'(44); waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk); issue = 1'b0; #1;
        check("to_req_read", 32'(read), 1);
        check("to_req_stall", 32'(stall), 1);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk); #1;
        check("to_not_yet", 32'(timeout), 0);
        check("to_still_read", 32'(read), 1);
        @(posedge clk);
        @(negedge clk); #1;
        check("to_timeout", 32'(timeout), 1);
        check("to_stall", 32'(stall), 1);
        check("to_read", 32'(read), 0);
        check("to_write", 32'(write), 0);
        check("to_wait_count", 32'(wait_count), TIMEOUT);
        issue = 1'b1; instruction_code = CODE_W'(47); waitrequest = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("to_sticky_timeout", 32'(timeout), 1);
        check("to_sticky_read", 32'(read), 0);
        check("to_sticky_done", 32'(done), 0);
        apply_reset();

        // Reset in the middle of a refused request.
        @(negedge clk);
        issue = 1'b1; instruction_code = CODE_W'(47); waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk); issue = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("mid_read", 32'(read), 1);
        check("mid_wait_count", 32'(wait_count), 2);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_read", 32'(read), 0);
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_wait_count", 32'(wait_count), 0);
        check("mid_rst_access_size", 32'(access_size), 0);
        #1 reset = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk); do_access(51, 1);

        // Randomized mix of idle cycles, non-memory and memory issues.
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                issue       = 1'b0;
                waitrequest = 1'($urandom);
                @(posedge clk);
            end else if (r == 1) begin
                do code = $urandom_range(0, 127); while (ref_index(code) >= 0);
                do_access(code, 0);
            end else begin
                code = ref_codes[$urandom_range(0, 9)];
                do_access(code, $urandom_range(0, TIMEOUT - 1));
            end
        end

        @(negedge clk); issue = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
